// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port integer register file.
package regfile_pkg;

    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;

    // Lowest bit of slice idx in a flat bus built from w-bit slices.
    function automatic int slice_base(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking between issue and writeback, with read-side lookup.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run_i,
    input  logic [NRD*AW-1:0] rd_addr_i,
    input  logic [NWR-1:0]    wr_en_i,
    input  logic [NWR*AW-1:0] wr_addr_i,
    input  logic              iss_en_i,
    input  logic [AW-1:0]     iss_addr_i,
    output logic [NRD-1:0]    rd_busy_o,
    output logic              iss_ok_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Writeback releases first, then issue claims, so a new producer wins a collision.
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NWR; w++) begin
            busy_d[wr_addr_i[slice_base(w, AW) +: AW]] =
                (run_i && wr_en_i[w]) ? 1'b0 : busy_d[wr_addr_i[slice_base(w, AW) +: AW]];
        end
        busy_d[iss_addr_i] = (run_i && iss_en_i) ? 1'b1 : busy_d[iss_addr_i];
        busy_d[0] = 1'b0;
    end

    // Busy flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar r = 0; r < NRD; r++) begin : g_rd_busy
        logic [AW-1:0] addr_s;
        logic          wb_hit_s;

        assign addr_s = rd_addr_i[slice_base(r, AW) +: AW];

        // A writeback to this address in the same cycle hides the stored busy bit.
        always_comb begin
            wb_hit_s = 1'b0;
            for (int w = 0; w < NWR; w++) begin
                wb_hit_s = wb_hit_s || (wr_en_i[w] && (wr_addr_i[slice_base(w, AW) +: AW] == addr_s));
            end
        end

        assign rd_busy_o[r] = run_i && (addr_s != '0) && busy_q[addr_s] && !wb_hit_s;
    end

    assign iss_ok_o = run_i && (iss_addr_i != '0) && !busy_q[iss_addr_i];

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass, busy scoreboard and
// a post-reset sequential clear of the storage array.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    output logic                           ready,
    input  logic [NRD*$clog2(NREGS)-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0]            rd_data,
    output logic [NRD-1:0]                 rd_busy,
    input  logic [NWR-1:0]                 wr_en,
    input  logic [NWR*$clog2(NREGS)-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0]            wr_data,
    input  logic                           iss_en,
    input  logic [$clog2(NREGS)-1:0]       iss_addr,
    output logic                           iss_ok
);

    localparam int AW = $clog2(NREGS);

    rf_state_t       state_q;
    rf_state_t       state_d;
    logic [AW-1:0]   clr_idx_q;
    logic [AW-1:0]   clr_idx_d;
    logic [XLEN-1:0] regs_q [NREGS];
    logic            run_s;

    // Clear-sequence state and index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RF_CLEAR;
            clr_idx_q <= AW'(1);
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Walk clr_idx from 1 up to NREGS-1, then hand over to RUN.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            RF_CLEAR: begin
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == AW'(NREGS - 1)) begin
                    state_d = RF_RUN;
                end else begin
                    state_d = RF_CLEAR;
                end
            end
            RF_RUN: begin
                state_d   = RF_RUN;
                clr_idx_d = clr_idx_q;
            end
            default: begin
                state_d   = RF_CLEAR;
                clr_idx_d = AW'(1);
            end
        endcase
    end

    assign run_s = (state_q == RF_RUN);
    assign ready = run_s;

    // Storage has no reset; CLEAR zeroes one entry per cycle, later write ports win.
    always_ff @(posedge clk) begin
        if (!run_s) begin
            regs_q[clr_idx_q] <= '0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && (wr_addr[slice_base(w, AW) +: AW] != '0)) begin
                    regs_q[wr_addr[slice_base(w, AW) +: AW]] <= wr_data[slice_base(w, XLEN) +: XLEN];
                end
            end
        end
    end

    for (genvar r = 0; r < NRD; r++) begin : g_rd
        logic [AW-1:0]   addr_s;
        logic [XLEN-1:0] val_s;

        assign addr_s = rd_addr[slice_base(r, AW) +: AW];

        // Stored value, overridden by any same-cycle write; the highest port wins.
        always_comb begin
            val_s = regs_q[addr_s];
            for (int w = 0; w < NWR; w++) begin
                val_s = (wr_en[w] && (wr_addr[slice_base(w, AW) +: AW] == addr_s))
                        ? wr_data[slice_base(w, XLEN) +: XLEN] : val_s;
            end
        end

        assign rd_data[slice_base(r, XLEN) +: XLEN] = (run_s && (addr_s != '0)) ? val_s : '0;
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_i      (run_s),
        .rd_addr_i  (rd_addr),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .iss_en_i   (iss_en),
        .iss_addr_i (iss_addr),
        .rd_busy_o  (rd_busy),
        .iss_ok_o   (iss_ok)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: expectations are queued as stimulus is driven
// and compared against the DUT outputs once they have settled.
module tb_regfile_mp;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 ready;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic [NWR-1:0]       wr_en;
    logic [NWR*AW-1:0]    wr_addr;
    logic [NWR*XLEN-1:0]  wr_data;
    logic                 iss_en;
    logic [AW-1:0]        iss_addr;
    logic                 iss_ok;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ready    (ready),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .iss_ok   (iss_ok)
    );

    typedef struct {
        string       tag;
        int          kind;
        int          port;
        logic [63:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [63:0] mdl [NREGS];
    bit          mb [NREGS];
    bit          mrun;
    int          mclr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] observe(input int kind, input int port);
        case (kind)
            0:       return rd_data[port*XLEN +: XLEN];
            1:       return 64'(rd_busy[port]);
            2:       return 64'(iss_ok);
            3:       return 64'(ready);
            default: return '1;
        endcase
    endfunction

    function automatic void mreset();
        mrun = 1'b0;
        mclr = 1;
        foreach (mb[i]) mb[i] = 1'b0;
    endfunction

    function automatic void mclock();
        if (!mrun) begin
            mdl[mclr] = 64'd0;
            if (mclr == NREGS - 1) mrun = 1'b1;
            mclr++;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w]) begin
                    int a;
                    a = int'(wr_addr[w*AW +: AW]);
                    if (a != 0) mdl[a] = wr_data[w*XLEN +: XLEN];
                    mb[a] = 1'b0;
                end
            end
            if (iss_en && iss_addr != 0) mb[iss_addr] = 1'b1;
        end
    endfunction

    function automatic logic [63:0] m_rd(input int r);
        logic [AW-1:0] a;
        logic [63:0]   v;
        a = rd_addr[r*AW +: AW];
        if (!mrun || a == 0) return 64'd0;
        v = mdl[a];
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && wr_addr[w*AW +: AW] == a) v = wr_data[w*XLEN +: XLEN];
        end
        return v;
    endfunction

    function automatic bit m_busy(input int r);
        logic [AW-1:0] a;
        bit            hit;
        a = rd_addr[r*AW +: AW];
        hit = 1'b0;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && wr_addr[w*AW +: AW] == a) hit = 1'b1;
        end
        return mrun && (a != 0) && mb[a] && !hit;
    endfunction

    task automatic push(input string t, input int k, input int p, input logic [63:0] e);
        exp_t x;
        x.tag = t; x.kind = k; x.port = p; x.exp = e;
        sb_q.push_back(x);
    endtask

    task automatic drain();
        exp_t x;
        while (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            chk(x.tag, observe(x.kind, x.port), x.exp);
        end
    endtask

    // Let combinational outputs settle, then check them against the model.
    task automatic settle();
        #1;
        for (int r = 0; r < NRD; r++) begin
            push($sformatf("rd_data%0d", r), 0, r, m_rd(r));
            push($sformatf("rd_busy%0d", r), 1, r, 64'(m_busy(r)));
        end
        push("iss_ok", 2, 0, 64'(mrun && iss_addr != 0 && !mb[iss_addr]));
        push("ready", 3, 0, 64'(mrun));
        drain();
    endtask

    task automatic adv();
        @(posedge clk);
        if (rst_n) mclock();
        else mreset();
        @(negedge clk);
    endtask

    task automatic set_wr(input int w, input bit en, input int a, input logic [63:0] d);
        wr_en[w] = en;
        wr_addr[w*AW +: AW] = AW'(a);
        wr_data[w*XLEN +: XLEN] = d;
    endtask

    task automatic set_rd(input int r, input int a);
        rd_addr[r*AW +: AW] = AW'(a);
    endtask

    task automatic idle();
        wr_en = '0;
        iss_en = 1'b0;
    endtask

    task automatic count_clear(input string tag);
        int cnt;
        cnt = 0;
        while (!ready && cnt < 100) begin
            settle();
            adv();
            cnt++;
        end
        chk(tag, 64'(cnt), 64'd31);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0; rd_addr = '0;
        mreset();
        @(negedge clk);
        settle();
        adv();
        rst_n = 1'b1;

        // CLEAR with writes and issues that must be ignored
        set_wr(0, 1'b1, 12, 64'h0000_0000_0000_00AB);
        iss_en = 1'b1; iss_addr = 5'd13;
        set_rd(0, 12); set_rd(1, 13);
        count_clear("clear_len");
        idle();
        settle();
        push("drop_wr_clear", 0, 0, 64'd0);
        push("drop_iss_clear", 1, 1, 64'd0);
        drain();
        adv();
        for (int a = 0; a < NREGS; a += 2) begin
            set_rd(0, a); set_rd(1, a + 1);
            settle();
            adv();
        end

        // Same-cycle bypass and persistence
        set_wr(0, 1'b1, 5, 64'hDEAD_BEEF_0000_0001); set_rd(0, 5);
        settle(); push("x5_bypass", 0, 0, 64'hDEAD_BEEF_0000_0001); drain(); adv();
        idle();
        settle(); push("x5_hold", 0, 0, 64'hDEAD_BEEF_0000_0001); drain(); adv();

        // Two ports on the same register: port 1 wins
        set_wr(0, 1'b1, 7, 64'h11); set_wr(1, 1'b1, 7, 64'h22); set_rd(0, 7);
        settle(); push("x7_bypass", 0, 0, 64'h22); drain(); adv();
        idle();
        settle(); push("x7_stored", 0, 0, 64'h22); drain(); adv();

        // Register zero
        set_wr(0, 1'b1, 0, 64'hFF); set_rd(0, 0);
        settle(); push("x0_bypass", 0, 0, 64'd0); drain(); adv();
        idle();
        settle(); push("x0_stored", 0, 0, 64'd0); drain(); adv();

        // Issue, writeback release, and issue+writeback collision on x9
        iss_en = 1'b1; iss_addr = 5'd9; set_rd(0, 9);
        settle(); push("iss_ok_free", 2, 0, 64'd1); drain(); adv();
        iss_en = 1'b0;
        settle(); push("busy_after_iss", 1, 0, 64'd1); push("iss_ok_busy", 2, 0, 64'd0); drain(); adv();
        set_wr(0, 1'b1, 9, 64'h99);
        settle(); push("busy_wb_same", 1, 0, 64'd0); push("iss_ok_stored", 2, 0, 64'd0); drain(); adv();
        idle();
        settle(); push("busy_released", 1, 0, 64'd0); push("iss_ok_released", 2, 0, 64'd1); drain(); adv();
        iss_en = 1'b1; set_wr(0, 1'b1, 9, 64'h77);
        settle(); adv();
        idle();
        settle();
        push("set_wins", 1, 0, 64'd1); push("iss_ok_setwins", 2, 0, 64'd0); push("x9_value", 0, 0, 64'h77);
        drain(); adv();

        // Random traffic on a small address window to provoke collisions
        for (int i = 0; i < 60; i++) begin
            for (int w = 0; w < NWR; w++) begin
                set_wr(w, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), {$urandom, $urandom});
            end
            iss_en = 1'($urandom_range(0, 1));
            iss_addr = AW'($urandom_range(0, 7));
            set_rd(0, int'($urandom_range(0, 7))); set_rd(1, int'($urandom_range(0, 7)));
            settle();
            adv();
        end

        // Leave x20 holding data and x21 busy, then reset in RUN
        idle();
        set_wr(0, 1'b1, 20, 64'h2020); iss_en = 1'b1; iss_addr = 5'd21;
        settle(); adv();
        idle();
        set_rd(0, 21); set_rd(1, 20);
        settle(); push("x21_busy_pre", 1, 0, 64'd1); drain(); adv();
        rst_n = 1'b0; mreset();
        settle(); push("rst_busy", 1, 0, 64'd0); push("rst_ready", 3, 0, 64'd0); drain(); adv();
        rst_n = 1'b1;

        // Reset again mid-CLEAR at clr_idx 10; writes during CLEAR are dropped
        set_wr(0, 1'b1, 20, 64'h5555); iss_en = 1'b1; iss_addr = 5'd22;
        for (int i = 0; i < 9; i++) begin
            settle();
            adv();
        end
        rst_n = 1'b0; mreset();
        settle(); push("midclr_ready", 3, 0, 64'd0); drain(); adv();
        rst_n = 1'b1;
        count_clear("clear_len2");
        idle();
        set_rd(0, 20); set_rd(1, 22);
        settle(); push("x20_cleared", 0, 0, 64'd0); push("x22_not_busy", 1, 1, 64'd0); drain(); adv();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d of %0d passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-write, dual-read integer register file.
- Configurable XLEN, register count, read-port count and write-port count.
- Adds same-cycle write-to-read bypass, a per-register busy scoreboard for issue/writeback hazard tracking, and a post-reset sequential clear FSM.
- Sits between decode/issue (reads, scoreboard checks) and writeback (writes, busy release).

Parameters:
- XLEN, 64: data width per register.
- NREGS, 32: architectural register count; power of two, >= 4. Register 0 is hardwired zero.
- NRD, 2: number of read ports.
- NWR, 1: number of write ports, 1..4.
- AW, $clog2(NREGS): address width (derived, not overridable).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ready  out  1  high once the clear sequence has finished.
- rd_addr  in  NRD*AW  read addresses, port r at [r*AW +: AW].
- rd_data  out  NRD*XLEN  read data.
- rd_busy  out  NRD  scoreboard busy flag for each read address.
- wr_en  in  NWR  write enables.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- iss_en  in  1  issue: mark iss_addr busy.
- iss_addr  in  AW  destination register of the issuing instruction.
- iss_ok  out  1  iss_addr is non-zero and not busy (WAW-free issue).

Behaviour:
- FSM states CLEAR and RUN.
  - Async reset: state=CLEAR, clr_idx=1, busy[*]=0, ready=0.
  - In CLEAR, each cycle writes regs[clr_idx]<=0 and increments clr_idx.
  - When clr_idx==NREGS-1 (after that write), next state is RUN and ready=1 from the following cycle. CLEAR therefore lasts exactly NREGS-1 cycles.
  - In CLEAR, wr_en and iss_en are ignored; rd_data reads 0; rd_busy=0; iss_ok=0.
  - Reset asserted mid-CLEAR or in RUN restarts the full sequence.
- Reads are combinational, zero latency.
  - Address 0 returns 0 and busy=0.
  - Otherwise the value is regs[addr], overridden by bypass: if any wr_en[w] has wr_addr[w]==addr, return that wr_data. The highest w wins.
  - rd_busy[r] = busy[addr] && !(any wr_en[w] with wr_addr[w]==addr). Writeback releases the register in the same cycle it is read.
- Writes take effect on the clock edge, in RUN only.
  - Writes to address 0 are discarded.
  - Multiple ports writing the same address in one cycle: the highest port index wins.
- Scoreboard, updated on the clock edge in RUN:
  - busy[a] clears when any wr_en[w] has wr_addr[w]==a.
  - busy[a] sets when iss_en && iss_addr==a && a!=0.
  - If issue and writeback hit the same register in the same cycle, set wins: the new producer owns the register.
  - iss_en with iss_ok=0 is still honoured (busy stays set). Gating issue on iss_ok is the issuer's responsibility.
  - busy[0] is constantly 0.
- iss_ok = ready && iss_addr!=0 && !busy[iss_addr] (uses stored busy only, no bypass).
- Register contents are not reset directly by rst_n; the CLEAR sequence zeroes them.

Decomposition:
- Shared package regfile_pkg:
  - typedef enum {RF_CLEAR, RF_RUN} rf_state_t.
  - Localparam defaults XLEN_DEF=64, NREGS_DEF=32.
  - Function for port-slice extraction.
- One natural sub-module, regfile_scoreboard: owns busy[NREGS], iss_ok and the rd_busy lookup. Inputs are the write/issue ports and the run flag.

Test Plan:
- Reset release: ready=0 for 31 cycles with NREGS=32, then ready=1; every register reads 0; iss_ok=0 throughout CLEAR.
- In RUN, write x5=0xDEAD_BEEF_0000_0001 on port 0 while rd_addr[0]=5 in the same cycle -> rd_data[0]=0xDEAD_BEEF_0000_0001 combinationally; the value persists next cycle with wr_en=0.
- NWR=2, both ports write x7 (port0=0x11, port1=0x22) -> bypass and stored value are both 0x22. Write x0=0xFF -> read x0=0.
- Issue x9 -> next cycle rd_busy=1 and iss_ok(x9)=0. Writeback x9 -> rd_busy=0 in that cycle; busy clears at the edge. Issue and writeback of x9 in the same cycle -> busy stays 1.
- Assert rst_n low mid-CLEAR at clr_idx=10 -> busy=0, ready=0; after release, CLEAR runs a full 31 cycles again. Writes during CLEAR are dropped (read 0 afterwards).
